pointer_file: RTL and testbench

Parametrised pointer register file. It replaces the fixed two-pointer IP/DP pair with NPTR pointers of AW bits each. Each pointer is loaded a byte at a time from the internal data bus and counts up or down with a wrap flag. A rotating base maps logical pointer indices onto physical registers, which generalises the IP/DP swap. It sits between the internal data bus, the ALU B operand and the memory address bus, and is sequenced by the control unit.

---
 rtl/pointer_file_pkg.sv | 24 ++
 rtl/pointer_cell.sv | 52 +++++
 rtl/pointer_file.sv | 89 ++++++++
 tb/tb_pointer_file.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pointer_file_pkg.sv
// Shared constants, width helper and count-direction type for the pointer file.
package pointer_file_pkg;

  // Index width for v entries, never less than one bit.
  function automatic int clog2_min1(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  localparam int AW_DEFAULT   = 16;
  localparam int NPTR_DEFAULT = 4;
  localparam int PW = clog2_min1(NPTR_DEFAULT);
  localparam int BW = clog2_min1(AW_DEFAULT / 8);

  typedef enum logic {
    CNT_UP   = 1'b0,
    CNT_DOWN = 1'b1
  } cnt_dir_e;

endpackage

// File: rtl/pointer_cell.sv
// One AW-bit pointer: byte-lane load, up/down count, combinational wrap detect.
module pointer_cell
  import pointer_file_pkg::*;
#(
  parameter int AW = 16,
  parameter int BW = 1
) (
  input  logic          n_clk,
  input  logic          n_rst,
  input  logic          we,
  input  logic [BW-1:0] wbyte,
  input  logic [7:0]    di,
  input  logic          cnt,
  input  cnt_dir_e      dir,
  output logic [AW-1:0] q,
  output logic          wrap
);
  localparam int NB = AW / 8;

  logic [AW-1:0] q_r;
  logic [AW-1:0] nxt_s;

  // Next value: a lane write overrides counting; wrap flags the count roll-over.
  always_comb begin
    nxt_s = q_r;
    wrap  = 1'b0;
    if (we) begin
      for (int b = 0; b < NB; b++) begin
        if (wbyte == BW'(b)) nxt_s[b*8 +: 8] = di;
      end
    end else if (cnt) begin
      if (dir == CNT_DOWN) begin
        nxt_s = q_r - AW'(1);
        wrap  = (q_r == {AW{1'b0}});
      end else begin
        nxt_s = q_r + AW'(1);
        wrap  = &q_r;
      end
    end else begin
      nxt_s = q_r;
    end
  end

  // Pointer register with asynchronous clear.
  always_ff @(posedge n_clk or negedge n_rst) begin
    if (!n_rst) q_r <= {AW{1'b0}};
    else        q_r <= nxt_s;
  end

  assign q = q_r;

endmodule

// File: rtl/pointer_file.sv
// NPTR pointers behind a rotating logical-to-physical base, with byte load/readout.
module pointer_file
  import pointer_file_pkg::*;
#(
  parameter int AW   = 16,
  parameter int NPTR = 4,
  localparam int PW  = clog2_min1(NPTR),
  localparam int BW  = clog2_min1(AW / 8)
) (
  input  logic          n_clk,
  input  logic          n_rst,
  input  logic [7:0]    di,
  input  logic          we,
  input  logic [PW-1:0] wsel,
  input  logic [BW-1:0] wbyte,
  input  logic          inc,
  input  logic [PW-1:0] inc_sel,
  input  logic          dec,
  input  logic          rot,
  input  logic [PW-1:0] asel,
  output logic [AW-1:0] addr,
  input  logic [PW-1:0] rsel,
  input  logic [BW-1:0] rbyte,
  output logic [7:0]    dout,
  output logic [PW-1:0] base,
  output logic          wrap
);
  localparam int NB = AW / 8;

  logic [PW-1:0]   base_r;
  logic            wrap_r;
  logic [AW-1:0]   ptr_s [NPTR];
  logic [NPTR-1:0] cell_wrap_s;
  logic [PW-1:0]   wsel_p_s, inc_p_s, asel_p_s, rsel_p_s;
  logic            lane_ok_s, we_ok_s, conflict_s;
  logic [AW-1:0]   rword_s;

  // NPTR is a power of two, so PW-bit addition is the modulo mapping.
  assign wsel_p_s = wsel + base_r;
  assign inc_p_s  = inc_sel + base_r;
  assign asel_p_s = asel + base_r;
  assign rsel_p_s = rsel + base_r;

  assign lane_ok_s  = ({1'b0, wbyte} < (BW+1)'(NB));
  assign we_ok_s    = we && lane_ok_s;
  assign conflict_s = we_ok_s && (wsel_p_s == inc_p_s);

  for (genvar i = 0; i < NPTR; i++) begin : g_cell
    pointer_cell #(.AW(AW), .BW(BW)) u_cell (
      .n_clk (n_clk),
      .n_rst (n_rst),
      .we    (we_ok_s && (wsel_p_s == PW'(i))),
      .wbyte (wbyte),
      .di    (di),
      .cnt   (inc && (inc_p_s == PW'(i)) && !conflict_s),
      .dir   (cnt_dir_e'(dec)),
      .q     (ptr_s[i]),
      .wrap  (cell_wrap_s[i])
    );
  end

  // Rotation base; selects above always see the pre-rotation value.
  always_ff @(posedge n_clk or negedge n_rst) begin
    if (!n_rst)   base_r <= {PW{1'b0}};
    else if (rot) base_r <= base_r + PW'(1);
    else          base_r <= base_r;
  end

  // Wrap pulse: at most one cell counts per cycle, so OR-reduce is exact.
  always_ff @(posedge n_clk or negedge n_rst) begin
    if (!n_rst) wrap_r <= 1'b0;
    else        wrap_r <= |cell_wrap_s;
  end

  assign addr    = ptr_s[asel_p_s];
  assign rword_s = ptr_s[rsel_p_s];

  // Byte readout of the selected pointer.
  always_comb begin
    dout = 8'h00;
    for (int b = 0; b < NB; b++) begin
      if (rbyte == BW'(b)) dout = rword_s[b*8 +: 8];
    end
  end

  assign base = base_r;
  assign wrap = wrap_r;

endmodule

// File: tb/tb_pointer_file.sv
// Randomised and directed bench for pointer_file against an array-based reference model.
module tb_pointer_file;
  logic        n_clk = 1'b0;
  logic        n_rst = 1'b0;
  logic [7:0]  di = 8'h00;
  logic        we = 1'b0, inc = 1'b0, dec = 1'b0, rot = 1'b0;
  logic [1:0]  wsel = 2'd0, inc_sel = 2'd0, asel = 2'd0, rsel = 2'd0;
  logic        wbyte = 1'b0, rbyte = 1'b0;
  logic [15:0] addr;
  logic [7:0]  dout;
  logic [1:0]  base;
  logic        wrap;

  // Second instance with two pointers for the IP/DP swap scenario.
  logic [7:0]  di2 = 8'h00;
  logic        we2 = 1'b0, rot2 = 1'b0, wsel2 = 1'b0, wbyte2 = 1'b0, asel2 = 1'b0;
  logic [15:0] addr2;
  logic [7:0]  dout2;
  logic        base2, wrap2;

  int vectors = 0;
  int miscompares = 0;

  // Reference state: logical view is mptr[(l + mbase) % 4].
  logic [15:0] mptr [4];
  int          mbase;
  logic        mwrap;

  always #5 n_clk = ~n_clk;

  pointer_file #(.AW(16), .NPTR(4)) dut (
    .n_clk(n_clk), .n_rst(n_rst), .di(di), .we(we), .wsel(wsel), .wbyte(wbyte),
    .inc(inc), .inc_sel(inc_sel), .dec(dec), .rot(rot), .asel(asel), .addr(addr),
    .rsel(rsel), .rbyte(rbyte), .dout(dout), .base(base), .wrap(wrap)
  );

  pointer_file #(.AW(16), .NPTR(2)) dut2 (
    .n_clk(n_clk), .n_rst(n_rst), .di(di2), .we(we2), .wsel(wsel2), .wbyte(wbyte2),
    .inc(1'b0), .inc_sel(1'b0), .dec(1'b0), .rot(rot2), .asel(asel2), .addr(addr2),
    .rsel(asel2), .rbyte(1'b1), .dout(dout2), .base(base2), .wrap(wrap2)
  );

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) mptr[i] = 16'h0000;
    mbase = 0;
    mwrap = 1'b0;
  endfunction

  // Applies the operation rules to the model for one clock edge.
  function automatic void model_edge();
    int pw, pi;
    logic nw;
    pw = (int'(wsel) + mbase) % 4;
    pi = (int'(inc_sel) + mbase) % 4;
    nw = 1'b0;
    if (we) begin
      if (wbyte) mptr[pw] = {di, mptr[pw][7:0]};
      else       mptr[pw] = {mptr[pw][15:8], di};
    end
    if (inc && !(we && pw == pi)) begin
      if (dec) begin
        nw = (mptr[pi] == 16'h0000);
        mptr[pi] = mptr[pi] - 16'd1;
      end else begin
        nw = (mptr[pi] == 16'hFFFF);
        mptr[pi] = mptr[pi] + 16'd1;
      end
    end
    if (rot) mbase = (mbase + 1) % 4;
    mwrap = nw;
  endfunction

  function automatic logic [15:0] m_logical(input int l);
    return mptr[(l + mbase) % 4];
  endfunction

  // One clock with the currently driven controls, then return to idle.
  task automatic apply();
    @(posedge n_clk);
    model_edge();
    #1;
    we = 1'b0; inc = 1'b0; rot = 1'b0; dec = 1'b0;
  endtask

  task automatic write_ptr(input logic [1:0] l, input logic [15:0] v);
    we = 1'b1; wsel = l; wbyte = 1'b0; di = v[7:0];
    apply();
    we = 1'b1; wsel = l; wbyte = 1'b1; di = v[15:8];
    apply();
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    model_reset();
    #12;
    for (int l = 0; l < 4; l++) begin
      asel = 2'(l); rsel = 2'(l); rbyte = 1'(l);
      #1;
      vectors++;
      if (addr !== 16'h0000 || dout !== 8'h00 || base !== 2'd0 || wrap !== 1'b0) begin
        miscompares++;
        $display("FAIL reset l=%0d: addr=%h dout=%h base=%0d wrap=%b, required all 0", l, addr, dout, base, wrap);
      end
    end
    @(negedge n_clk);
    n_rst = 1'b1;
    @(negedge n_clk);
  endtask

  task automatic test_load();
    we = 1'b1; wsel = 2'd1; wbyte = 1'b0; di = 8'h34;
    apply();
    we = 1'b1; wsel = 2'd1; wbyte = 1'b1; di = 8'h12;
    apply();
    asel = 2'd1; rsel = 2'd1; rbyte = 1'b1;
    #1;
    vectors++;
    if (addr !== 16'h1234) begin
      miscompares++;
      $display("FAIL load_addr: got %h, required 1234", addr);
    end
    vectors++;
    if (dout !== 8'h12) begin
      miscompares++;
      $display("FAIL load_dout: got %h, required 12", dout);
    end
  endtask

  task automatic test_wrap();
    write_ptr(2'd0, 16'hFFFF);
    asel = 2'd0;
    inc = 1'b1; inc_sel = 2'd0; dec = 1'b0;
    apply();
    vectors++;
    if (addr !== 16'h0000 || wrap !== 1'b1) begin
      miscompares++;
      $display("FAIL wrap_inc: addr=%h wrap=%b, required 0000 1", addr, wrap);
    end
    apply();
    vectors++;
    if (wrap !== 1'b0) begin
      miscompares++;
      $display("FAIL wrap_pulse: wrap=%b, required 0", wrap);
    end
    inc = 1'b1; inc_sel = 2'd0; dec = 1'b1;
    apply();
    vectors++;
    if (addr !== 16'hFFFF || wrap !== 1'b1) begin
      miscompares++;
      $display("FAIL wrap_dec: addr=%h wrap=%b, required ffff 1", addr, wrap);
    end
  endtask

  task automatic test_carry();
    write_ptr(2'd0, 16'h00FF);
    asel = 2'd0;
    inc = 1'b1; inc_sel = 2'd0; dec = 1'b0;
    apply();
    vectors++;
    if (addr !== 16'h0100 || wrap !== 1'b0) begin
      miscompares++;
      $display("FAIL carry: addr=%h wrap=%b, required 0100 0", addr, wrap);
    end
  endtask

  task automatic test_conflict();
    write_ptr(2'd0, 16'h0010);
    we = 1'b1; wsel = 2'd0; wbyte = 1'b0; di = 8'hAA;
    inc = 1'b1; inc_sel = 2'd0;
    asel = 2'd0;
    apply();
    vectors++;
    if (addr !== 16'h00AA || wrap !== 1'b0) begin
      miscompares++;
      $display("FAIL conflict: addr=%h wrap=%b, required 00aa 0", addr, wrap);
    end
    write_ptr(2'd0, 16'h0010);
    we = 1'b1; wsel = 2'd0; wbyte = 1'b0; di = 8'hAA;
    inc = 1'b1; inc_sel = 2'd0; rot = 1'b1;
    apply();
    // Base is now 1: logical 3 is the old physical 0, logical 0 is pointer 1.
    asel = 2'd3;
    #1;
    vectors++;
    if (addr !== 16'h00AA || base !== 2'd1 || wrap !== 1'b0) begin
      miscompares++;
      $display("FAIL conflict_rot: addr=%h base=%0d wrap=%b, required 00aa 1 0", addr, base, wrap);
    end
    asel = 2'd0;
    #1;
    vectors++;
    if (addr !== 16'h1234) begin
      miscompares++;
      $display("FAIL conflict_rot_l0: addr=%h, required 1234", addr);
    end
  endtask

  task automatic test_swap();
    we2 = 1'b1; wsel2 = 1'b0; wbyte2 = 1'b1; di2 = 8'h10;
    @(posedge n_clk); #1;
    we2 = 1'b1; wsel2 = 1'b1; wbyte2 = 1'b1; di2 = 8'h20;
    @(posedge n_clk); #1;
    we2 = 1'b0; rot2 = 1'b1; asel2 = 1'b0;
    @(posedge n_clk); #1;
    rot2 = 1'b0;
    vectors++;
    if (addr2 !== 16'h2000 || base2 !== 1'b1 || dout2 !== 8'h20) begin
      miscompares++;
      $display("FAIL swap1: addr=%h base=%b dout=%h, required 2000 1 20", addr2, base2, dout2);
    end
    rot2 = 1'b1;
    @(posedge n_clk); #1;
    rot2 = 1'b0;
    vectors++;
    if (addr2 !== 16'h1000 || base2 !== 1'b0) begin
      miscompares++;
      $display("FAIL swap2: addr=%h base=%b, required 1000 0", addr2, base2);
    end
  endtask

  task automatic test_random();
    logic [15:0] exp_a;
    logic [15:0] exp_r;
    logic [7:0]  exp_d;
    for (int n = 0; n < 400; n++) begin
      we = 1'($urandom_range(0, 1)); wsel = 2'($urandom); wbyte = 1'($urandom);
      di = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
      inc = 1'($urandom_range(0, 2) != 0); inc_sel = 2'($urandom);
      dec = 1'($urandom); rot = ($urandom_range(0, 5) == 0);
      asel = 2'($urandom); rsel = 2'($urandom); rbyte = 1'($urandom);
      apply();
      exp_a = m_logical(int'(asel));
      exp_r = m_logical(int'(rsel));
      exp_d = rbyte ? exp_r[15:8] : exp_r[7:0];
      vectors++;
      if (addr !== exp_a || dout !== exp_d || base !== 2'(mbase) || wrap !== mwrap) begin
        miscompares++;
        $display("FAIL random n=%0d: addr=%h dout=%h base=%0d wrap=%b, required %h %h %0d %b",
                 n, addr, dout, base, wrap, exp_a, exp_d, mbase, mwrap);
      end
    end
  endtask

  task automatic test_reset_mid();
    rot = 1'b1;
    write_ptr(2'd2, 16'hBEEF);
    we = 1'b1; wsel = 2'd1; wbyte = 1'b0; di = 8'h77;
    apply();
    inc = 1'b1; inc_sel = 2'd2; dec = 1'b0;
    @(negedge n_clk);
    n_rst = 1'b0;
    model_reset();
    #1;
    for (int l = 0; l < 4; l++) begin
      asel = 2'(l); rsel = 2'(l); rbyte = 1'b0;
      #1;
      vectors++;
      if (addr !== 16'h0000 || dout !== 8'h00 || base !== 2'd0 || wrap !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_mid l=%0d: addr=%h dout=%h base=%0d wrap=%b, required all 0", l, addr, dout, base, wrap);
      end
    end
    @(posedge n_clk); #1;
    inc = 1'b0;
    vectors++;
    if (addr !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset_hold: addr=%h, required 0000", addr);
    end
    @(negedge n_clk);
    n_rst = 1'b1;
    test_load();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_load();
    test_wrap();
    test_carry();
    test_conflict();
    test_swap();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
